conv_encoder_param: RTL
=======================

// Module: conv_encoder_param
// PURPOSE
//  Parametrised rate-1/2 feed-forward convolutional encoder; successor to the fixed K=3 encoder.
//  Per-frame choice of K=3 (fixed polys 7,5 octal) or K=K_MAX (parameter polys).
//  Automatic zero-tail termination, valid/ready on both sides, optional rate-2/3 puncturing.
//  Sits between the bit source and the modulator/decoder test path.
// PARAMETERS
//  K_MAX   7         long constraint length, 4..9
//  G0_L    7'o171    output-0 generator for K_MAX; MSB taps the current input bit
//  G1_L    7'o133    output-1 generator for K_MAX
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous, active-low reset
//  k_sel      in   1  0: K=3 (G0=3'o7, G1=3'o5); 1: K=K_MAX; sampled on a frame's first accepted bit
//  punct      in   1  1: rate-2/3 puncturing; sampled with k_sel; ignored unless CONV_PUNCT_EN
//  in_valid   in   1  input bit valid
//  in_ready   out  1  encoder accepts in_bit this cycle
//  in_bit     in   1  information bit
//  in_last    in   1  final information bit of the frame
//  out_valid  out  1  out_sym valid
//  out_ready  in   1  downstream accepts the symbol
//  out_sym    out  2  [1]=G0 parity, [0]=G1 parity
//  out_mask   out  2  per-bit keep flags for out_sym; 2'b11 when not punctured
//  out_last   out  1  final (tail) symbol of the frame
// BEHAVIOUR
//  Reset: state IDLE, shift register 0, out_valid=0, out_sym=0, out_mask=2'b11, out_last=0, phase=0.
//  Shift register sr[K_MAX-2:0]; sr[0]=most recent past bit.
//  For K=3, only sr[1:0] are used: {u, sr[0], sr[1]} dotted with G (MSB x u).
//  Parity: c_j = ^(G_j & {u, sr[0..K-2]}), where u is the encoded bit (data or tail 0).
//  Each encode step: sr <= {sr[K-3:0], u}; sr bits >= K-1 are held at 0.
//  Single output register, 1-cycle latency: a symbol is presented the cycle after acceptance.
//  Advance condition: adv = !out_valid || out_ready.
//  FSM:
//   IDLE : in_ready=adv. On in_valid&&adv: latch k_sel/punct; encode; ->DATA, or ->FLUSH if in_last.
//   DATA : in_ready=adv. Each in_valid&&adv encodes one bit; in_last -> FLUSH, tail counter=K-1.
//   FLUSH: in_ready=0. Each adv encodes u=0 and decrements the counter.
//          On the last tail: out_last=1, sr cleared, ->IDLE.
//  The output holds stable while out_valid && !out_ready.
//  out_valid drops only when the symbol is consumed with no new symbol.
//  Back-to-back frames: IDLE accepts a new first bit in the same cycle the last tail is consumed.
//  k_sel/punct changes mid-frame are ignored until the next frame start.
//  in_last on the very first bit gives a 1-bit frame plus K-1 tails.
//  Reset mid-frame aborts immediately: no tail is emitted, all outputs return to reset values.
// CONFIGURATION
//  CONV_PUNCT_EN defined:
//   With latched punct=1, symbol phase toggles per emitted symbol and resets to 0 at frame start.
//   Phase 0 -> out_mask=2'b11; phase 1 -> out_mask=2'b10 (G1 bit dropped). Tail symbols included.
//   out_sym still carries both parities.
//  CONV_PUNCT_EN undefined: punct ignored, out_mask tied to 2'b11, no phase register.
// STRUCTURE
//  Package conv_pkg: localparams POLY_K3_G0=3'o7, POLY_K3_G1=3'o5, FSM state encoding (IDLE/DATA/FLUSH).
//  Package conv_pkg: function parity(poly,vec).
//  Sub-module conv_parity_core: combinational taps/parity for the selected K; shared if multi-rate is added.
// TESTING
//  K=3, bits 1,0,1,1 (last on 4th), out_ready=1:
//   -> out_sym 11,10,00,01,01,11; out_last on 6th; in_ready low for 2 tail cycles.
//  K=K_MAX=7 impulse, single bit 1 with in_last:
//   -> 11,10,11,11,00,01,11 (polys 171/133 octal), out_last on 7th.
//  Backpressure, K=3 data 1,0,1,1, out_ready toggling 1010...:
//   -> same 6 symbols, each held stable while stalled; no bit lost or duplicated.
//  Back-to-back frames, K=3 then K=7, no idle cycle:
//   -> second frame starts from sr=0; its first symbol follows the first frame's out_last.
//  Reset asserted low during FLUSH:
//   -> out_valid=0 asynchronously; after release, next frame's output matches a fresh-reset run.
//  CONV_PUNCT_EN, punct=1, K=3 data 1,0,1,1:
//   -> out_mask 11,10,11,10,11,10 with out_sym unchanged from scenario 1.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM encoding and parity helper for the convolutional encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  // Widest constraint length the parity helper supports; K_MAX must not exceed it.
  localparam int K_LIM = 9;

  // Fixed short-code generators, MSB taps the current input bit.
  localparam logic [2:0] POLY_K3_G0 = 3'o7;
  localparam logic [2:0] POLY_K3_G1 = 3'o5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } conv_state_t;

  // Modulo-2 inner product of a generator with the tap vector (both zero-extended).
  function automatic logic parity(input logic [K_LIM-1:0] poly, input logic [K_LIM-1:0] vec);
    return ^(poly & vec);
  endfunction

endpackage

// File: rtl/conv_parity_core.sv
// conv_parity_core: parity pair for one encode step, K=3 or K=K_MAX generators.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
//   k_long : 0 selects the fixed K=3 polys (7,5), 1 selects G0_L/G1_L
//   u      : bit being encoded (data or tail zero)
//   sr     : past bits, sr[0] most recent
//   sym    : [1]=G0 parity, [0]=G1 parity
module conv_parity_core
  import conv_pkg::*;
#(
  parameter int               K_MAX = 7,
  parameter logic [K_MAX-1:0] G0_L  = 7'o171,
  parameter logic [K_MAX-1:0] G1_L  = 7'o133
) (
  input  logic             k_long,
  input  logic             u,
  input  logic [K_MAX-2:0] sr,
  output logic [1:0]       sym
);

  logic [K_MAX-1:0] vec_l;
  logic [2:0]       vec_3;

  // Tap vector is MSB-first: u, then sr[0], sr[1], ... so the generator MSB hits u.
  always_comb begin
    vec_l = '0;
    vec_l[K_MAX-1] = u;
    for (int i = 0; i < K_MAX - 1; i++) begin
      vec_l[K_MAX-2-i] = sr[i];
    end
  end

  assign vec_3 = {u, sr[0], sr[1]};

  always_comb begin
    sym = 2'b00;
    if (k_long) begin
      sym[1] = parity(K_LIM'(G0_L), K_LIM'(vec_l));
      sym[0] = parity(K_LIM'(G1_L), K_LIM'(vec_l));
    end else begin
      sym[1] = parity(K_LIM'(POLY_K3_G0), K_LIM'(vec_3));
      sym[0] = parity(K_LIM'(POLY_K3_G1), K_LIM'(vec_3));
    end
  end

endmodule

// File: rtl/conv_encoder_param.sv
// conv_encoder_param: rate-1/2 feed-forward convolutional encoder, K=3 or K=K_MAX per frame, zero-tail.
// Latency: 1 cycle from input acceptance (or tail step) to out_sym; single output register.
// Backpressure: advances only when the output register is empty or being consumed; holds otherwise.
//   clk, rst (async, active low)
//   k_sel, punct          : frame options, sampled on a frame's first accepted bit
//   in_valid/in_ready/in_bit/in_last : information bit stream
//   out_valid/out_ready/out_sym/out_mask/out_last : coded symbol stream
//   Optional CONV_PUNCT_EN: rate-2/3 puncturing via out_mask (out_mask tied 2'b11 when undefined).
module conv_encoder_param
  import conv_pkg::*;
#(
  parameter int               K_MAX = 7,
  parameter logic [K_MAX-1:0] G0_L  = 7'o171,
  parameter logic [K_MAX-1:0] G1_L  = 7'o133
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k_sel,
  input  logic       punct,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic [1:0] out_mask,
  output logic       out_last
);

  localparam int             CW     = $clog2(K_MAX);
  localparam logic [CW-1:0]  TAIL_L = CW'(K_MAX - 1);
  localparam logic [CW-1:0]  TAIL_3 = CW'(2);
  // Short code only ever uses sr[1:0]; upper bits stay zero.
  localparam logic [K_MAX-2:0] SR_MASK_K3 = {{(K_MAX-3){1'b0}}, 2'b11};

  conv_state_t      state, state_nxt;
  logic             k_lat;
  logic [K_MAX-2:0] sr;
  logic [K_MAX-2:0] sr_nxt;
  logic [CW-1:0]    tail_cnt;
  logic             adv;
  logic             enc;
  logic             u;
  logic             k_cur;
  logic             load_tail;
  logic             last_tail;
  logic             frame_start;
  logic [1:0]       sym_nxt;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and step control
  // ---------------------------------------------------------------------------
  always_comb begin
    adv       = !out_valid || out_ready;
    state_nxt = state;
    in_ready  = 1'b0;
    enc       = 1'b0;
    u         = 1'b0;
    load_tail = 1'b0;
    last_tail = 1'b0;
    // Frame options come straight from the port on the first bit, from the latch afterwards.
    k_cur     = (state == ST_IDLE) ? k_sel : k_lat;
    case (state)
      ST_IDLE, ST_DATA: begin
        in_ready = adv;
        if (in_valid && adv) begin
          enc = 1'b1;
          u   = in_bit;
          if (in_last) begin
            state_nxt = ST_FLUSH;
            load_tail = 1'b1;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_FLUSH: begin
        if (adv) begin
          enc = 1'b1;
          u   = 1'b0;
          if (tail_cnt == CW'(1)) begin
            last_tail = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_start = enc && (state == ST_IDLE);
  assign sr_nxt      = {sr[K_MAX-3:0], u} & (k_cur ? {(K_MAX-1){1'b1}} : SR_MASK_K3);

  conv_parity_core #(
    .K_MAX (K_MAX),
    .G0_L  (G0_L),
    .G1_L  (G1_L)
  ) u_parity (
    .k_long (k_cur),
    .u      (u),
    .sr     (sr),
    .sym    (sym_nxt)
  );

  // ---------------------------------------------------------------------------
  // Shift register, tail counter and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_lat     <= 1'b0;
      sr        <= '0;
      tail_cnt  <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
    end else begin
      if (frame_start) begin
        k_lat <= k_sel;
      end
      if (enc) begin
        // Clearing on the final tail leaves the next frame starting from zero state.
        sr <= last_tail ? '0 : sr_nxt;
      end
      if (load_tail) begin
        tail_cnt <= k_cur ? TAIL_L : TAIL_3;
      end else if (enc && (state == ST_FLUSH)) begin
        tail_cnt <= tail_cnt - CW'(1);
      end
      if (adv) begin
        out_valid <= enc;
        out_last  <= last_tail;
        if (enc) begin
          out_sym <= sym_nxt;
        end
      end
    end
  end

`ifdef CONV_PUNCT_EN
  logic       p_lat;
  logic       phase;
  logic [1:0] mask_q;

  // phase is the phase of the next symbol to be emitted; the frame's first symbol is phase 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_lat  <= 1'b0;
      phase  <= 1'b0;
      mask_q <= 2'b11;
    end else begin
      if (frame_start) begin
        p_lat  <= punct;
        phase  <= 1'b1;
        mask_q <= 2'b11;
      end else if (enc) begin
        phase  <= ~phase;
        mask_q <= (p_lat && phase) ? 2'b10 : 2'b11;
      end
    end
  end

  assign out_mask = mask_q;
`else
  logic unused_punct;
  assign unused_punct = punct;
  assign out_mask     = 2'b11;
`endif

endmodule
